reg_sequencer: RTL and testbench

Command-list executor that sits between `register_memory` and the serial bus master driving the accelerometer. On `start` it walks the command ROM from address 0: it fetches each 32-bit command word, decodes it, and issues a register read or write to the bus master over a valid/ready handshake. Read results are forwarded downstream to the display path. Execution ends at an end-of-list marker, or restarts from a loop point for continuous polling.

---
 rtl/reg_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_reg_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_sequencer.sv
// reg_sequencer: walks a command ROM and issues register reads/writes
// to a serial bus master, forwarding read results downstream.
module reg_sequencer #(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int LOOP_ENABLE    = 0,
    parameter int LOOP_ADDR      = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    input  logic [31:0]           read_data,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_rw,
    output logic [6:0]            cmd_dev_addr,
    output logic [7:0]            cmd_reg_addr,
    output logic [7:0]            cmd_wdata,
    input  logic                  rsp_valid,
    input  logic                  rsp_nack,
    input  logic [7:0]            rsp_rdata,
    output logic                  rd_valid,
    output logic [7:0]            rd_reg_addr,
    output logic [7:0]            rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            error_code
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    localparam logic [7:0] OP_END = 8'h00;
    localparam logic [7:0] OP_RD  = 8'h01;
    localparam logic [7:0] OP_WR  = 8'h02;

    localparam logic [3:0] E_NONE  = 4'd0;
    localparam logic [3:0] E_BADOP = 4'd1;
    localparam logic [3:0] E_NACK  = 4'd2;
    localparam logic [3:0] E_TMO   = 4'd3;
    localparam logic [3:0] E_OVF   = 4'd4;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  valid_q, valid_d;
    logic                  rw_q, rw_d;
    logic [6:0]            dev_q, dev_d;
    logic [7:0]            rega_q, rega_d;
    logic [7:0]            wdata_q, wdata_d;
    logic                  rdv_q, rdv_d;
    logic [7:0]            rdr_q, rdr_d;
    logic [7:0]            rdd_q, rdd_d;
    logic                  done_q, done_d;
    logic [3:0]            err_q, err_d;
    logic [TW-1:0]         tmo_q, tmo_d;

    logic [7:0] opcode;
    logic       unused_dev_msb;

    assign opcode         = read_data[31:24];
    assign unused_dev_msb = read_data[23];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        rw_d    = rw_q;
        dev_d   = dev_q;
        rega_d  = rega_q;
        wdata_d = wdata_q;
        rdv_d   = 1'b0;
        rdr_d   = rdr_q;
        rdd_d   = rdd_q;
        done_d  = 1'b0;
        err_d   = err_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    addr_d  = '0;
                    err_d   = E_NONE;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_RD || opcode == OP_WR) begin
                    rw_d    = (opcode == OP_RD);
                    dev_d   = read_data[22:16];
                    rega_d  = read_data[15:8];
                    wdata_d = (opcode == OP_RD) ? 8'h00 : read_data[7:0];
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end else if (opcode == OP_END) begin
                    done_d = 1'b1;
                    if (LOOP_ENABLE != 0) begin
                        addr_d  = ADDR_WIDTH'(LOOP_ADDR);
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    err_d   = E_BADOP;
                    state_d = S_ERROR;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    valid_d = 1'b0;
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response in the same cycle as the limit still wins
                if (rsp_valid) begin
                    if (rsp_nack) begin
                        err_d   = E_NACK;
                        state_d = S_ERROR;
                    end else begin
                        if (rw_q) begin
                            rdv_d = 1'b1;
                            rdr_d = rega_q;
                            rdd_d = rsp_rdata;
                        end
                        state_d = S_NEXT;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = E_TMO;
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_NEXT: begin
                if (&addr_q) begin
                    err_d   = E_OVF;
                    state_d = S_ERROR;
                end else begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            dev_q   <= '0;
            rega_q  <= '0;
            wdata_q <= '0;
            rdv_q   <= 1'b0;
            rdr_q   <= '0;
            rdd_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= E_NONE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            rw_q    <= rw_d;
            dev_q   <= dev_d;
            rega_q  <= rega_d;
            wdata_q <= wdata_d;
            rdv_q   <= rdv_d;
            rdr_q   <= rdr_d;
            rdd_q   <= rdd_d;
            done_q  <= done_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    assign reg_addr     = addr_q;
    assign cmd_valid    = valid_q;
    assign cmd_rw       = rw_q;
    assign cmd_dev_addr = dev_q;
    assign cmd_reg_addr = rega_q;
    assign cmd_wdata    = wdata_q;
    assign rd_valid     = rdv_q;
    assign rd_reg_addr  = rdr_q;
    assign rd_data      = rdd_q;
    assign done         = done_q;
    assign error_code   = err_q;
    assign busy         = (state_q != S_IDLE) && (state_q != S_ERROR);

endmodule

// File: tb/tb_reg_sequencer.sv
// Scoreboard bench for reg_sequencer: a bus responder model, a command ROM
// model and a monitor that pops expected requests and read results.
module tb_reg_sequencer;

    typedef struct packed {
        logic       rw;
        logic [6:0] dev;
        logic [7:0] rg;
        logic [7:0] wd;
    } cmd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, cmd_ready, rsp_valid, rsp_nack;
    logic [7:0]  rsp_rdata;
    logic [31:0] read_data;
    logic [7:0]  reg_addr;
    logic        cmd_valid, cmd_rw, rd_valid, busy, done;
    logic [6:0]  cmd_dev_addr;
    logic [7:0]  cmd_reg_addr, cmd_wdata, rd_reg_addr, rd_data;
    logic [3:0]  error_code;

    logic        start_l, cmd_ready_l, rsp_valid_l, rsp_nack_l;
    logic [7:0]  rsp_rdata_l;
    logic [31:0] read_data_l;
    logic [7:0]  reg_addr_l;
    logic        cmd_valid_l, cmd_rw_l, rd_valid_l, busy_l, done_l;
    logic [6:0]  cmd_dev_addr_l;
    logic [7:0]  cmd_reg_addr_l, cmd_wdata_l, rd_reg_addr_l, rd_data_l;
    logic [3:0]  error_code_l;

    reg_sequencer #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .reset(reset), .start(start),
        .reg_addr(reg_addr), .read_data(read_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_nack(rsp_nack),
        .rsp_rdata(rsp_rdata), .rd_valid(rd_valid),
        .rd_reg_addr(rd_reg_addr), .rd_data(rd_data), .busy(busy),
        .done(done), .error_code(error_code)
    );

    reg_sequencer #(.ADDR_WIDTH(8), .LOOP_ENABLE(1), .LOOP_ADDR(2)) dut_l (
        .clk(clk), .reset(reset), .start(start_l),
        .reg_addr(reg_addr_l), .read_data(read_data_l),
        .cmd_valid(cmd_valid_l), .cmd_ready(cmd_ready_l), .cmd_rw(cmd_rw_l),
        .cmd_dev_addr(cmd_dev_addr_l), .cmd_reg_addr(cmd_reg_addr_l),
        .cmd_wdata(cmd_wdata_l), .rsp_valid(rsp_valid_l),
        .rsp_nack(rsp_nack_l), .rsp_rdata(rsp_rdata_l),
        .rd_valid(rd_valid_l), .rd_reg_addr(rd_reg_addr_l),
        .rd_data(rd_data_l), .busy(busy_l), .done(done_l),
        .error_code(error_code_l)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [31:0] mem [256];

    cmd_t       exp_cmd [$];
    logic [15:0] exp_rd [$];
    logic [7:0] rdq [$];
    logic [7:0] log_l [$];

    int   hs_cnt = 0;
    int   hs_cyc = 0;
    int   done_l_cnt = 0;
    int   bp_left = 0;
    bit   hs_flag = 0, hs_rw = 0, pend = 0, pend_rw = 0;
    bit   resp_en = 1, nack_wr = 0, hs_l = 0;
    bit   pv_valid = 0, pv_ready = 0;
    cmd_t pv_cmd, cur, e;
    logic [15:0] er;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] outs_m();
        return {8'h0, busy, reg_addr, cmd_valid, cmd_rw, cmd_dev_addr,
                cmd_reg_addr, cmd_wdata, rd_valid, rd_reg_addr, rd_data,
                done, error_code};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        read_data   <= mem[reg_addr];
        read_data_l <= mem[reg_addr_l];
    end

    // bus master model for the main instance
    always @(posedge clk) begin
        #1;
        rsp_valid = 1'b0;
        rsp_nack  = 1'b0;
        rsp_rdata = 8'h00;
        if (pend) begin
            pend      = 0;
            rsp_valid = 1'b1;
            rsp_nack  = nack_wr && !pend_rw;
            if (pend_rw && !rsp_nack)
                rsp_rdata = (rdq.size() != 0) ? rdq.pop_front() : 8'hFF;
        end
        if (hs_flag) begin
            hs_flag = 0;
            if (resp_en) begin
                pend    = 1;
                pend_rw = hs_rw;
            end
        end
        if (cmd_valid && !cmd_rw && bp_left > 0) begin
            cmd_ready = 1'b0;
            bp_left--;
        end else begin
            cmd_ready = 1'b1;
        end
        rsp_valid_l = hs_l;
        hs_l = 0;
    end

    always @(negedge clk) begin
        if (!reset) begin
            cur = {cmd_rw, cmd_dev_addr, cmd_reg_addr, cmd_wdata};
            if (cmd_valid && cmd_ready) begin
                hs_cnt++;
                hs_cyc  = cyc;
                hs_flag = 1;
                hs_rw   = cmd_rw;
                chk("req_expected", exp_cmd.size() != 0, 1);
                if (exp_cmd.size() != 0) begin
                    e = exp_cmd.pop_front();
                    chk("req", cur, e);
                end
            end
            if (cmd_valid && pv_valid && !pv_ready)
                chk("req_stable", cur, pv_cmd);
            pv_valid = cmd_valid;
            pv_ready = cmd_ready;
            pv_cmd   = cur;
            if (rd_valid) begin
                chk("rd_expected", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0) begin
                    er = exp_rd.pop_front();
                    chk("rd", {rd_reg_addr, rd_data}, er);
                end
            end
            if (cmd_valid_l && cmd_ready_l) begin
                hs_l = 1;
                log_l.push_back(cmd_reg_addr_l);
            end
            if (done_l) done_l_cnt++;
        end
    end

    task automatic push_cmd(input logic rw, input logic [7:0] rg,
                            input logic [7:0] wd);
        exp_cmd.push_back({rw, 7'h1d, rg, wd});
    endtask

    task automatic push_rd(input logic [7:0] rg, input logic [7:0] d);
        exp_rd.push_back({rg, d});
        rdq.push_back(d);
    endtask

    task automatic push_full();
        push_cmd(1, 8'h00, 8'h00);
        push_rd(8'h00, 8'hE5);
        push_cmd(0, 8'h2d, 8'h08);
        push_cmd(1, 8'h32, 8'h00);
        push_rd(8'h32, 8'h12);
        push_cmd(1, 8'h33, 8'h00);
        push_rd(8'h33, 8'h34);
    endtask

    task automatic start_pulse();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string nm);
        int n = 0;
        while (busy && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(nm, busy, 0);
    endtask

    logic [7:0] lexp [8];
    int h0;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        lexp = '{8'h00, 8'h2d, 8'h32, 8'h33, 8'h32, 8'h33, 8'h32, 8'h33};
        foreach (mem[i]) mem[i] = 32'h0;
        mem[0] = 32'h011d0000;
        mem[1] = 32'h021d2d08;
        mem[2] = 32'h011d3200;
        mem[3] = 32'h011d3300;
        mem[4] = 32'h00000000;
        reset = 1'b1; start = 1'b0; start_l = 1'b0;
        cmd_ready = 1'b1; rsp_valid = 1'b0; rsp_nack = 1'b0;
        rsp_rdata = 8'h00;
        cmd_ready_l = 1'b1; rsp_valid_l = 1'b0; rsp_nack_l = 1'b0;
        rsp_rdata_l = 8'h5A;
        repeat (2) @(posedge clk);
        #1 chk("reset_state", outs_m(), 0);
        reset = 1'b0;

        // loop instance
        @(posedge clk);
        #1 start_l = 1'b1;
        @(posedge clk);
        #1 start_l = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        chk("loop_req_count", log_l.size() >= 8, 1);
        for (int i = 0; i < 8; i++)
            if (i < log_l.size())
                chk($sformatf("loop_req%0d", i), log_l[i], lexp[i]);
        chk("loop_done_pulses", done_l_cnt >= 2, 1);
        chk("loop_busy", busy_l, 1);
        chk("loop_err", error_code_l, 0);

        // basic run
        push_full();
        h0 = hs_cnt;
        start_pulse();
        chk("start_busy", busy, 1);
        chk("start_addr", reg_addr, 0);
        @(posedge clk);
        #1 chk("cv_cycle2", cmd_valid, 0);
        @(posedge clk);
        #1 chk("cv_cycle3", cmd_valid, 1);
        wait_idle(200, "basic_end");
        chk("basic_done", done, 1);
        chk("basic_err", error_code, 0);
        chk("basic_sb", exp_cmd.size() + exp_rd.size(), 0);
        chk("basic_reqs", hs_cnt - h0, 4);
        @(posedge clk);
        #1 chk("done_pulse", done, 0);

        // backpressure on the write
        bp_left = 10;
        push_full();
        h0 = hs_cnt;
        start_pulse();
        wait_idle(300, "bp_end");
        chk("bp_done", done, 1);
        chk("bp_err", error_code, 0);
        chk("bp_sb", exp_cmd.size() + exp_rd.size(), 0);
        chk("bp_reqs", hs_cnt - h0, 4);
        chk("bp_used", bp_left, 0);

        // NACK on the write, then restart
        nack_wr = 1;
        push_cmd(1, 8'h00, 8'h00);
        push_rd(8'h00, 8'hE5);
        push_cmd(0, 8'h2d, 8'h08);
        h0 = hs_cnt;
        start_pulse();
        wait_idle(200, "nack_end");
        chk("nack_err", error_code, 2);
        chk("nack_done", done, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("nack_cv", cmd_valid, 0);
        chk("nack_reqs", hs_cnt - h0, 2);
        chk("nack_hold", error_code, 2);
        chk("nack_sb", exp_cmd.size() + exp_rd.size(), 0);
        nack_wr = 0;
        push_full();
        h0 = hs_cnt;
        start_pulse();
        chk("nack_clear", error_code, 0);
        wait_idle(200, "rerun_end");
        chk("rerun_done", done, 1);
        chk("rerun_err", error_code, 0);
        chk("rerun_reqs", hs_cnt - h0, 4);
        chk("rerun_sb", exp_cmd.size() + exp_rd.size(), 0);

        // timeout
        resp_en = 0;
        push_cmd(1, 8'h00, 8'h00);
        start_pulse();
        wait_idle(200, "tmo_end");
        chk("tmo_err", error_code, 3);
        chk("tmo_cycles", cyc - hs_cyc, 51);
        chk("tmo_sb", exp_cmd.size(), 0);
        resp_en = 1;

        // bad opcode in word 1
        mem[1] = 32'h051d2d08;
        push_cmd(1, 8'h00, 8'h00);
        push_rd(8'h00, 8'hE5);
        h0 = hs_cnt;
        start_pulse();
        wait_idle(200, "badop_end");
        chk("badop_err", error_code, 1);
        chk("badop_reqs", hs_cnt - h0, 1);
        chk("badop_done", done, 0);
        chk("badop_sb", exp_cmd.size() + exp_rd.size(), 0);
        mem[1] = 32'h021d2d08;

        // async reset while waiting for the response
        push_cmd(1, 8'h00, 8'h00);
        push_rd(8'h00, 8'hE5);
        h0 = hs_cnt;
        start_pulse();
        for (int n = 0; n < 20 && hs_cnt == h0; n++) begin
            @(posedge clk);
            #1;
        end
        chk("ar_reached", hs_cnt - h0, 1);
        chk("ar_busy_before", busy, 1);
        #2 reset = 1'b1;
        #1 chk("ar_outputs", outs_m(), 0);
        pend = 0;
        hs_flag = 0;
        exp_cmd.delete();
        exp_rd.delete();
        rdq.delete();
        @(posedge clk);
        #1 chk("ar_held", outs_m(), 0);
        reset = 1'b0;
        @(posedge clk);
        #1 chk("ar_after", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
